// File: rtl/relay_sequencer.sv
// Break-before-make sequencer for a shared bank of relay/switch channels.
// At most one coil is driven at a time, and channels are granted round-robin.
module relay_sequencer #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  req,
  input  logic [CNT_W-1:0] settle_cycles,
  input  logic [CNT_W-1:0] hold_cycles,
  input  logic [CNT_W-1:0] dead_cycles,
  output logic [N_CH-1:0]  drive,
  output logic [N_CH-1:0]  closed,
  output logic             busy,
  output logic             done
);

  localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PTR_W:0] N_SZ = (PTR_W+1)'(N_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, MAKE, ON, BREAK} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lim;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] cur;
  logic [PTR_W-1:0] ptr_next;

  logic [2*N_CH-1:0] rot;
  logic [PTR_W:0]    sum;
  logic [PTR_W-1:0]  pick;
  logic              pick_vld;
  logic [N_CH-1:0]   cur_oh;
  logic              req_cur;
  logic              req_other;
  logic              hold_met;

  // Rotate requests so bit 0 is the pointer channel; the lowest set bit wins.
  always_comb begin
    rot      = {req, req} >> ptr;
    sum      = '0;
    pick     = ptr;
    pick_vld = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(i);
      if (sum >= N_SZ) sum = sum - N_SZ;
      if (rot[i]) begin
        pick     = sum[PTR_W-1:0];
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    cur_oh    = N_CH'(1) << cur;
    req_cur   = |(req & cur_oh);
    req_other = |(req & ~cur_oh);
    hold_met  = (cnt >= lim);
    ptr_next  = (cur == LAST_CH) ? '0 : cur + 1'b1;
  end

  // lim holds the timing value latched on entry to the current state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      lim    <= '0;
      ptr    <= '0;
      cur    <= '0;
      drive  <= '0;
      closed <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            cur   <= pick;
            drive <= N_CH'(1) << pick;
            cnt   <= '0;
            lim   <= settle_cycles;
            busy  <= 1'b1;
            state <= MAKE;
          end
        end
        MAKE: begin
          if (cnt == lim) begin
            closed <= drive;
            cnt    <= '0;
            lim    <= hold_cycles;
            state  <= ON;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          if (hold_met && (!req_cur || req_other)) begin
            drive  <= '0;
            closed <= '0;
            cnt    <= '0;
            lim    <= dead_cycles;
            ptr    <= ptr_next;
            state  <= BREAK;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (cnt == lim) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_relay_sequencer.sv
// Bench for relay_sequencer: directed scenarios then random traffic, each cycle
// compared with a phase/countdown model of the sequencing rules.
module tb_relay_sequencer;

  localparam int N  = 4;
  localparam int CW = 16;

  localparam int P_IDLE  = 0;
  localparam int P_MAKE  = 1;
  localparam int P_ON    = 2;
  localparam int P_BREAK = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [CW-1:0] settle_cycles;
  logic [CW-1:0] hold_cycles;
  logic [CW-1:0] dead_cycles;
  logic [N-1:0]  drive;
  logic [N-1:0]  closed;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: phase, granted channel, countdown of remaining cycles.
  int m_phase = P_IDLE;
  int m_ch    = 0;
  int m_ptr   = 0;
  int m_left  = 0;
  int m_age   = 0;
  int m_hold  = 0;
  int m_gap   = 1;
  bit m_done  = 1'b0;

  logic [31:0] last_nz  = '0;
  int          zero_run = 0;

  relay_sequencer #(.N_CH(N), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .settle_cycles (settle_cycles),
    .hold_cycles   (hold_cycles),
    .dead_cycles   (dead_cycles),
    .drive         (drive),
    .closed        (closed),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int first_req();
    logic [31:0] r;
    int c;
    r = 32'(req);
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (((r >> c) & 32'd1) != 32'd0) return c;
    end
    return -1;
  endfunction

  task automatic model_edge();
    logic [31:0] r;
    logic [31:0] mine;
    int c;
    r    = 32'(req);
    mine = 32'd1 << m_ch;
    m_done = 1'b0;
    if (rst) begin
      m_phase = P_IDLE;
      m_ptr   = 0;
      m_ch    = 0;
      last_nz = '0;
    end else begin
      case (m_phase)
        P_IDLE: begin
          c = first_req();
          if (c >= 0) begin
            m_ch    = c;
            m_left  = int'(settle_cycles);
            m_phase = P_MAKE;
          end
        end
        P_MAKE: begin
          if (m_left == 0) begin
            m_phase = P_ON;
            m_age   = 0;
            m_hold  = int'(hold_cycles);
          end else m_left--;
        end
        P_ON: begin
          if (m_age >= m_hold && (((r & mine) == 0) || ((r & ~mine) != 0))) begin
            m_phase = P_BREAK;
            m_left  = int'(dead_cycles);
            m_gap   = int'(dead_cycles) + 1;
            m_ptr   = (m_ch + 1) % N;
          end else m_age++;
        end
        default: begin
          if (m_left == 0) begin
            m_phase = P_IDLE;
            m_done  = 1'b1;
          end else m_left--;
        end
      endcase
    end
  endtask

  task automatic compare();
    logic [31:0] exp_drive;
    logic [31:0] exp_closed;
    exp_drive  = (m_phase == P_MAKE || m_phase == P_ON) ? (32'd1 << m_ch) : 32'd0;
    exp_closed = (m_phase == P_ON) ? (32'd1 << m_ch) : 32'd0;
    check("drive",  32'(drive),  exp_drive);
    check("closed", 32'(closed), exp_closed);
    check("busy",   32'(busy),   32'(m_phase != P_IDLE));
    check("done",   32'(done),   32'(m_done));
    check("onehot_drive", 32'($countones(drive) <= 1), 32'd1);
    check("closed_subset", 32'(closed == '0 || closed == drive), 32'd1);
    if (drive != '0) begin
      if (last_nz != '0 && 32'(drive) != last_nz)
        check("dead_gap", 32'(zero_run >= m_gap), 32'd1);
      last_nz  = 32'(drive);
      zero_run = 0;
    end else begin
      zero_run++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic timing(input int s, input int h, input int d);
    settle_cycles = CW'(s);
    hold_cycles   = CW'(h);
    dead_cycles   = CW'(d);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    timing(0, 0, 0);
    run(3);
    rst = 1'b0;
    run(2);

    // single request, then drop
    timing(2, 3, 1);
    req = 4'b0001;
    run(20);
    req = 4'b0000;
    run(6);

    // two requesters contending
    timing(0, 2, 2);
    req = 4'b0110;
    run(30);
    req = 4'b0000;
    run(8);

    // pointer wrap from channel 3 to channel 0
    timing(1, 1, 0);
    req = 4'b0100;
    run(4);
    req = 4'b1001;
    run(25);
    req = 4'b0000;
    run(6);

    // one-cycle request must still complete its hold
    timing(1, 5, 1);
    req = 4'b0100;
    run(1);
    req = 4'b0000;
    run(15);

    // reset while channel 3 is closed
    timing(1, 20, 3);
    req = 4'b1000;
    run(6);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    req = 4'b1111;
    run(10);
    req = 4'b0000;
    run(30);

    // hold change mid-ON has no effect
    timing(0, 10, 1);
    req = 4'b0001;
    run(3);
    hold_cycles = CW'(1);
    req = 4'b0011;
    run(20);
    req = 4'b0000;
    run(8);

    // random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0)
        timing(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0;
    req = '0;
    run(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
